// File: rtl/alu_issue_stage_pkg.sv
// Shared types and constants for the ALU issue stage.
package alu_issue_stage_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned WIDTH__REG_IDX = 4;
    localparam int unsigned OPER_WIDTH     = 4;

    // ALU operation codes, 16 values
    typedef enum logic [OPER_WIDTH-1:0] {
        AluAdd, AluSub, AluAnd, AluOr, AluXor, AluSll, AluSrl, AluSra,
        AluSlt, AluSltu, AluNor, AluXnor, AluMin, AluMax, AluAndn, AluNand
    } alu_oper_e;

    // Decoded instruction as presented to the issue stage
    typedef struct packed {
        alu_oper_e                   oper;
        logic [WIDTH__REG_IDX-1:0]   ra_idx;
        logic [WIDTH__REG_IDX-1:0]   rb_idx;
        logic [DATA_WIDTH_DEF-1:0]   ra_data;
        logic [DATA_WIDTH_DEF-1:0]   rb_data;
        logic                        use_imm;
        logic [DATA_WIDTH_DEF-1:0]   imm;
        logic [WIDTH__REG_IDX-1:0]   rd_idx;
    } port_in_alu_issue_t;

    // One result-forwarding path
    typedef struct packed {
        logic                        valid;
        logic [WIDTH__REG_IDX-1:0]   idx;
        logic [DATA_WIDTH_DEF-1:0]   data;
    } fwd_path_t;

endpackage

// File: rtl/alu_issue_skid.sv
// Two-entry valid/ready buffer: an output register plus one skid slot.
// in_ready depends only on registered state; flush kills both entries.
module alu_issue_skid #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;

    // Next-state: drain skid first to keep FIFO order, park in skid when stalled
    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_data_d   = out_data_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_valid) begin
                out_data_d  = in_data;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_valid && !skid_valid_q) begin
            skid_data_d  = in_data;
            skid_valid_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_data_q   <= '0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_data_q   <= out_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    // Outputs
    always_comb begin
        in_ready  = !skid_valid_q;
        out_valid = out_valid_q;
        out_data  = out_data_q;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: operand resolve with EX/WB forwarding, load-use stall,
// and a registered oper/a/b/rd bundle behind a 2-entry skid buffer.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int unsigned REG_IDX_WIDTH = WIDTH__REG_IDX
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPER_WIDTH-1:0]    in_oper,
    input  logic [REG_IDX_WIDTH-1:0] in_ra_idx,
    input  logic [REG_IDX_WIDTH-1:0] in_rb_idx,
    input  logic [DATA_WIDTH-1:0]    in_ra_data,
    input  logic [DATA_WIDTH-1:0]    in_rb_data,
    input  logic                     in_use_imm,
    input  logic [DATA_WIDTH-1:0]    in_imm,
    input  logic [REG_IDX_WIDTH-1:0] in_rd_idx,
    input  logic                     ex_fwd_valid,
    input  logic [REG_IDX_WIDTH-1:0] ex_fwd_idx,
    input  logic [DATA_WIDTH-1:0]    ex_fwd_data,
    input  logic                     wb_fwd_valid,
    input  logic [REG_IDX_WIDTH-1:0] wb_fwd_idx,
    input  logic [DATA_WIDTH-1:0]    wb_fwd_data,
    input  logic                     load_pend_valid,
    input  logic [REG_IDX_WIDTH-1:0] load_pend_idx,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPER_WIDTH-1:0]    out_oper,
    output logic [DATA_WIDTH-1:0]    out_a,
    output logic [DATA_WIDTH-1:0]    out_b,
    output logic [REG_IDX_WIDTH-1:0] out_rd_idx
);

    localparam int unsigned PAYLOAD_W = OPER_WIDTH + 2 * DATA_WIDTH + REG_IDX_WIDTH;

    logic [DATA_WIDTH-1:0] a_res, b_reg_res, b_res;
    logic                  hazard;
    logic                  skid_in_ready;
    logic                  accept;
    logic [PAYLOAD_W-1:0]  in_payload, out_payload;

    // Resolve sources: r0 is zero, EX forwarding beats WB, then register file
    always_comb begin
        if (in_ra_idx == '0) begin
            a_res = '0;
        end else if (ex_fwd_valid && ex_fwd_idx == in_ra_idx) begin
            a_res = ex_fwd_data;
        end else if (wb_fwd_valid && wb_fwd_idx == in_ra_idx) begin
            a_res = wb_fwd_data;
        end else begin
            a_res = in_ra_data;
        end

        if (in_rb_idx == '0) begin
            b_reg_res = '0;
        end else if (ex_fwd_valid && ex_fwd_idx == in_rb_idx) begin
            b_reg_res = ex_fwd_data;
        end else if (wb_fwd_valid && wb_fwd_idx == in_rb_idx) begin
            b_reg_res = wb_fwd_data;
        end else begin
            b_reg_res = in_rb_data;
        end

        b_res = in_use_imm ? in_imm : b_reg_res;
    end

    // Load-use hazard; rb is irrelevant when the immediate supplies B
    always_comb begin
        hazard = load_pend_valid && (load_pend_idx != '0) &&
                 ((load_pend_idx == in_ra_idx) ||
                  (!in_use_imm && (load_pend_idx == in_rb_idx)));
    end

    // Handshake: rst_n gating keeps in_ready low while reset is asserted
    always_comb begin
        in_ready   = skid_in_ready && !hazard && rst_n;
        accept     = in_valid && in_ready && !flush;
        in_payload = {in_oper, a_res, b_res, in_rd_idx};
    end

    alu_issue_skid #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (accept),
        .in_ready  (skid_in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload)
    );

    // Unpack the registered bundle
    always_comb begin
        {out_oper, out_a, out_b, out_rd_idx} = out_payload;
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: forwarding, hazard, skid ordering,
// flush and mid-stall reset.
module tb_alu_issue_stage;
    import alu_issue_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_oper;
    logic [3:0]  in_ra_idx, in_rb_idx, in_rd_idx;
    logic [31:0] in_ra_data, in_rb_data, in_imm;
    logic        in_use_imm;
    logic        ex_fwd_valid, wb_fwd_valid, load_pend_valid;
    logic [3:0]  ex_fwd_idx, wb_fwd_idx, load_pend_idx;
    logic [31:0] ex_fwd_data, wb_fwd_data;
    logic        out_valid, out_ready;
    logic [3:0]  out_oper, out_rd_idx;
    logic [31:0] out_a, out_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_oper         (in_oper),
        .in_ra_idx       (in_ra_idx),
        .in_rb_idx       (in_rb_idx),
        .in_ra_data      (in_ra_data),
        .in_rb_data      (in_rb_data),
        .in_use_imm      (in_use_imm),
        .in_imm          (in_imm),
        .in_rd_idx       (in_rd_idx),
        .ex_fwd_valid    (ex_fwd_valid),
        .ex_fwd_idx      (ex_fwd_idx),
        .ex_fwd_data     (ex_fwd_data),
        .wb_fwd_valid    (wb_fwd_valid),
        .wb_fwd_idx      (wb_fwd_idx),
        .wb_fwd_data     (wb_fwd_data),
        .load_pend_valid (load_pend_valid),
        .load_pend_idx   (load_pend_idx),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_oper        (out_oper),
        .out_a           (out_a),
        .out_b           (out_b),
        .out_rd_idx      (out_rd_idx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [3:0] op, input logic [3:0] ra, input logic [31:0] rad,
                             input logic [3:0] rb, input logic [31:0] rbd,
                             input logic [3:0] rd);
        in_oper    = op;
        in_ra_idx  = ra;
        in_ra_data = rad;
        in_rb_idx  = rb;
        in_rb_data = rbd;
        in_rd_idx  = rd;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_use_imm = 1'b0; in_imm = '0;
        ex_fwd_valid = 1'b0; ex_fwd_idx = '0; ex_fwd_data = '0;
        wb_fwd_valid = 1'b0; wb_fwd_idx = '0; wb_fwd_data = '0;
        load_pend_valid = 1'b0; load_pend_idx = '0;
        set_instr(4'd0, 4'd0, 32'h0, 4'd0, 32'h0, 4'd0);

        // Reset state
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_a", out_a, 32'd0);
        chk("rst_out_oper", 32'(out_oper), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Basic issue
        tick();
        in_valid = 1'b1; out_ready = 1'b1;
        set_instr(4'(AluAdd), 4'd3, 32'd5, 4'd4, 32'd7, 4'd9);
        tick();
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_a", out_a, 32'd5);
        chk("basic_b", out_b, 32'd7);
        chk("basic_rd", 32'(out_rd_idx), 32'd9);
        chk("basic_oper", 32'(out_oper), 32'(AluAdd));
        chk("basic_in_ready", 32'(in_ready), 32'd1);

        // Forwarding priority
        ex_fwd_valid = 1'b1; ex_fwd_idx = 4'd2; ex_fwd_data = 32'hAA;
        wb_fwd_valid = 1'b1; wb_fwd_idx = 4'd2; wb_fwd_data = 32'hBB;
        set_instr(4'(AluSub), 4'd2, 32'h11, 4'd0, 32'h44, 4'd1);
        tick();
        chk("fwd_ex_a", out_a, 32'hAA);
        chk("fwd_r0_b", out_b, 32'h0);
        chk("fwd_oper", 32'(out_oper), 32'(AluSub));
        ex_fwd_valid = 1'b0;
        set_instr(4'(AluXor), 4'd2, 32'h11, 4'd2, 32'h22, 4'd2);
        tick();
        chk("fwd_wb_a", out_a, 32'hBB);
        chk("fwd_wb_b", out_b, 32'hBB);
        set_instr(4'(AluOr), 4'd0, 32'h11, 4'd7, 32'h77, 4'd3);
        tick();
        chk("fwd_r0_a", out_a, 32'h0);
        chk("reg_b", out_b, 32'h77);
        wb_fwd_valid = 1'b0;

        // Load-use hazard
        load_pend_valid = 1'b1; load_pend_idx = 4'd5;
        set_instr(4'(AluAdd), 4'd5, 32'h55, 4'd1, 32'h1, 4'd4);
        #1;
        chk("haz_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("haz_no_valid", 32'(out_valid), 32'd0);
        set_instr(4'(AluAnd), 4'd1, 32'h33, 4'd5, 32'h55, 4'd6);
        in_use_imm = 1'b1; in_imm = 32'h10;
        #1;
        chk("imm_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("imm_valid", 32'(out_valid), 32'd1);
        chk("imm_a", out_a, 32'h33);
        chk("imm_b", out_b, 32'h10);
        load_pend_valid = 1'b0; in_use_imm = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("drain_idle", 32'(out_valid), 32'd0);

        // Backpressure with three back-to-back instructions
        out_ready = 1'b0; in_valid = 1'b1;
        set_instr(4'd2, 4'd1, 32'h101, 4'd2, 32'h201, 4'd1);
        tick();
        chk("bp_i1_valid", 32'(out_valid), 32'd1);
        chk("bp_i1_a", out_a, 32'h101);
        set_instr(4'd2, 4'd1, 32'h102, 4'd2, 32'h202, 4'd2);
        tick();
        chk("bp_hold_a", out_a, 32'h101);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        set_instr(4'd2, 4'd1, 32'h103, 4'd2, 32'h203, 4'd3);
        tick();
        chk("bp_hold_a2", out_a, 32'h101);
        chk("bp_hold_rd", 32'(out_rd_idx), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_i2_a", out_a, 32'h102);
        chk("bp_i2_rd", 32'(out_rd_idx), 32'd2);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        tick();
        chk("bp_i3_a", out_a, 32'h103);
        chk("bp_i3_b", out_b, 32'h203);
        in_valid = 1'b0;
        tick();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Flush with skid full
        out_ready = 1'b0; in_valid = 1'b1;
        set_instr(4'd3, 4'd1, 32'h104, 4'd0, 32'h0, 4'd4);
        tick();
        set_instr(4'd3, 4'd1, 32'h105, 4'd0, 32'h0, 4'd5);
        tick();
        set_instr(4'd3, 4'd1, 32'h106, 4'd0, 32'h0, 4'd6);
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("flush_no_ghost1", 32'(out_valid), 32'd0);
        tick();
        chk("flush_no_ghost2", 32'(out_valid), 32'd0);

        // Reset while skid full
        out_ready = 1'b0; in_valid = 1'b1;
        set_instr(4'd4, 4'd1, 32'h107, 4'd0, 32'h0, 4'd7);
        tick();
        set_instr(4'd4, 4'd1, 32'h108, 4'd0, 32'h0, 4'd8);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        chk("mrst_a", out_a, 32'h0);
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        set_instr(4'(AluNand), 4'd6, 32'h99, 4'd0, 32'h0, 4'd10);
        tick();
        chk("mrst_issue_valid", 32'(out_valid), 32'd1);
        chk("mrst_issue_a", out_a, 32'h99);
        chk("mrst_issue_oper", 32'(out_oper), 32'(AluNand));
        in_valid = 1'b0;
        tick();
        chk("final_idle", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
